// File: rtl/rc4_pkg.sv
// Shared definitions for the RC4 datapath blocks (shuffle stage and
// keystream/decrypt stage).
//   MSG_LEN_DEFAULT : default number of encrypted bytes
//   ASCII_LO/HI/SP  : accepted plaintext bytes ('a'..'z' and space)
//   state_t         : decrypt FSM states, one clock each
package rc4_pkg;

   localparam int         MSG_LEN_DEFAULT = 32;

   localparam logic [7:0] ASCII_LO = 8'h61;
   localparam logic [7:0] ASCII_HI = 8'h7A;
   localparam logic [7:0] ASCII_SP = 8'h20;

   typedef enum logic [3:0] {
      IDLE,
      INC_I,
      ADDR_SI,
      LATCH_SI,
      CALC_J,
      ADDR_SJ,
      LATCH_SJ,
      WR_SI,
      WR_SJ,
      ADDR_F,
      LATCH_F,
      WR_OUT,
      CHECK,
      DONE
   } state_t;

endpackage

// File: rtl/prga_decrypt_ascii_check.sv
// Combinational plaintext filter.
//   data : decrypted byte
//   ok   : 1 when data is a lowercase letter or a space
module ascii_check
   import rc4_pkg::*;
(
   input  logic [7:0] data,
   output logic       ok
);

   assign ok = ((data >= ASCII_LO) && (data <= ASCII_HI)) || (data == ASCII_SP);

endmodule

// File: rtl/prga_decrypt.sv
// RC4 keystream generator and decryptor, run over an S-memory that has
// already been shuffled by the key-schedule stage.
//   clk, reset_n           : clock, asynchronous active-low reset
//   start                  : level, sampled only in IDLE
//   s_address/s_data/s_wren: S-memory port; s_q returns data one cycle
//                            after s_address is presented
//   rom_address/rom_q      : encrypted byte k, rom_q valid one cycle later
//   ram_address/ram_data/
//   ram_wren               : decrypted byte k
//   complete               : one-cycle pulse in DONE
//   valid                  : run result, held until the next accepted start
//   state_dbg              : current FSM state
//
// Handshake: there is no back-pressure. start is accepted in IDLE only;
// complete pulses for exactly one cycle in DONE; valid is meaningful from
// that pulse until the next accepted start. Memories are synchronous-read:
// an address driven in an ADDR_* state is captured from s_q in the
// following LATCH_* state.
module prga_decrypt
   import rc4_pkg::*;
#(
   parameter int MSG_LEN = MSG_LEN_DEFAULT,
   parameter int AW      = 5
)(
   input  logic          clk,
   input  logic          reset_n,
   input  logic          start,
   input  logic [7:0]    s_q,
   output logic [7:0]    s_address,
   output logic [7:0]    s_data,
   output logic          s_wren,
   input  logic [7:0]    rom_q,
   output logic [AW-1:0] rom_address,
   output logic [AW-1:0] ram_address,
   output logic [7:0]    ram_data,
   output logic          ram_wren,
   output logic          complete,
   output logic          valid,
   output state_t        state_dbg
);

   localparam logic [AW-1:0] K_LAST = AW'(MSG_LEN - 1);

   state_t        state, state_next;
   logic [7:0]    i, j;
   logic [7:0]    si, sj, f;
   logic [7:0]    out_byte;
   logic [AW-1:0] k;
   logic [7:0]    f_idx;
   logic [7:0]    wr_byte;
   logic          byte_ok;

   // Sums wrap mod 256 by width.
   assign f_idx   = si + sj;
   assign wr_byte = f ^ rom_q;

   ascii_check u_ascii_check (
      .data (out_byte),
      .ok   (byte_ok)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         i        <= '0;
         j        <= '0;
         k        <= '0;
         si       <= '0;
         sj       <= '0;
         f        <= '0;
         out_byte <= '0;
         valid    <= 1'b0;
      end else begin
         state <= state_next;
         case (state)
            IDLE:     if (start) valid <= 1'b0;
            INC_I:    i <= i + 8'd1;
            LATCH_SI: si <= s_q;
            CALC_J:   j <= j + si;
            LATCH_SJ: sj <= s_q;
            LATCH_F:  f <= s_q;
            WR_OUT:   out_byte <= wr_byte;
            CHECK: begin
               if (!byte_ok)         valid <= 1'b0;
               else if (k == K_LAST) valid <= 1'b1;
               else                  k <= k + 1'b1;
            end
            DONE: begin
               i <= '0;
               j <= '0;
               k <= '0;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:     if (start) state_next = INC_I;
         INC_I:    state_next = ADDR_SI;
         ADDR_SI:  state_next = LATCH_SI;
         LATCH_SI: state_next = CALC_J;
         CALC_J:   state_next = ADDR_SJ;
         ADDR_SJ:  state_next = LATCH_SJ;
         LATCH_SJ: state_next = WR_SI;
         WR_SI:    state_next = WR_SJ;
         WR_SJ:    state_next = ADDR_F;
         ADDR_F:   state_next = LATCH_F;
         LATCH_F:  state_next = WR_OUT;
         WR_OUT:   state_next = CHECK;
         CHECK:    state_next = (!byte_ok || k == K_LAST) ? DONE : INC_I;
         DONE:     state_next = IDLE;
         default:  state_next = IDLE;
      endcase
   end

   // Swap uses the latched old values: S[i] <= S[j]old, then S[j] <= S[i]old.
   always_comb begin
      s_address = 8'h00;
      s_data    = 8'h00;
      s_wren    = 1'b0;
      ram_data  = 8'h00;
      ram_wren  = 1'b0;
      case (state)
         ADDR_SI: s_address = i;
         ADDR_SJ: s_address = j;
         WR_SI: begin
            s_address = i;
            s_data    = sj;
            s_wren    = 1'b1;
         end
         WR_SJ: begin
            s_address = j;
            s_data    = si;
            s_wren    = 1'b1;
         end
         ADDR_F: s_address = f_idx;
         WR_OUT: begin
            ram_data = wr_byte;
            ram_wren = 1'b1;
         end
         default: ;
      endcase
   end

   assign rom_address = k;
   assign ram_address = k;
   assign complete    = (state == DONE);
   assign state_dbg   = state;

endmodule

// File: tb/tb_prga_decrypt.sv
module tb_prga_decrypt;
   import rc4_pkg::*;

   localparam int N  = 32;
   localparam int AW = 5;

   // ---------------- clock / reset / DUT ----------------
   logic          clk = 1'b0;
   logic          reset_n;
   logic          start;
   logic [7:0]    s_q;
   logic [7:0]    s_address, s_data;
   logic          s_wren;
   logic [7:0]    rom_q;
   logic [AW-1:0] rom_address, ram_address;
   logic [7:0]    ram_data;
   logic          ram_wren, complete, valid;
   state_t        state_dbg;

   always #5 clk = ~clk;

   prga_decrypt #(.MSG_LEN(N), .AW(AW)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .start       (start),
      .s_q         (s_q),
      .s_address   (s_address),
      .s_data      (s_data),
      .s_wren      (s_wren),
      .rom_q       (rom_q),
      .rom_address (rom_address),
      .ram_address (ram_address),
      .ram_data    (ram_data),
      .ram_wren    (ram_wren),
      .complete    (complete),
      .valid       (valid),
      .state_dbg   (state_dbg)
   );

   // ---------------- memories around the DUT ----------------
   logic [7:0] s_mem[256];
   logic [7:0] rom_mem[N];
   logic [7:0] ram_mem[N];

   always @(posedge clk) begin
      s_q   <= s_mem[s_address];
      rom_q <= rom_mem[rom_address];
      if (s_wren)   s_mem[s_address]   = s_data;
      if (ram_wren) ram_mem[ram_address] = ram_data;
   end

   // ---------------- bookkeeping ----------------
   int vectors = 0;
   int miscompares = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit is_text(input logic [7:0] b);
      return (b == 8'h20) || (b >= 8'h61 && b <= 8'h7A);
   endfunction

   // ---------------- reference model ----------------
   logic [7:0] r_s[256];
   logic [7:0] r_rom[N];
   logic [7:0] r_f[N];
   logic [7:0] r_out[N];
   int         r_bytes;
   bit         r_valid;
   logic [7:0] r_first_j, r_first_fidx;

   logic [15:0] exp_s_q[$];
   logic [15:0] exp_ram_q[$];

   // Runs the RC4 keystream on r_s in place. With record set it also decrypts
   // r_rom, queues every S and RAM write and stops after the first non-text byte.
   task automatic prga_ref(input bit record);
      logic [7:0] i, j, t, f, o;
      i = 8'd0; j = 8'd0; r_bytes = N; r_valid = 1'b1;
      for (int k = 0; k < N; k++) begin
         i = i + 8'd1;
         j = j + r_s[i];
         if (record) begin
            exp_s_q.push_back({i, r_s[j]});
            exp_s_q.push_back({j, r_s[i]});
         end
         if (k == 0) begin
            r_first_j    = j;
            r_first_fidx = 8'(r_s[i] + r_s[j]);
         end
         t = r_s[i]; r_s[i] = r_s[j]; r_s[j] = t;
         f = r_s[8'(r_s[i] + r_s[j])];
         r_f[k] = f;
         if (record) begin
            o = f ^ r_rom[k];
            r_out[k] = o;
            exp_ram_q.push_back({3'b000, 5'(k), o});
            if (!is_text(o)) begin
               r_valid = 1'b0;
               r_bytes = k + 1;
               break;
            end
         end
      end
   endtask

   // Builds ROM contents from the current S so the plaintext is 'a' (or random
   // text), with an optional non-text byte planted at bad_k.
   task automatic prep_rom(input int bad_k, input logic [7:0] bad_v, input bit rnd);
      logic [7:0] tgt;
      int v;
      r_s = s_mem;
      prga_ref(1'b0);
      for (int k = 0; k < N; k++) begin
         if (rnd) begin
            v = $urandom_range(0, 26);
            tgt = (v == 26) ? 8'h20 : 8'(8'h61 + v);
         end else begin
            tgt = 8'h61;
         end
         if (k == bad_k) tgt = bad_v;
         rom_mem[k] = r_f[k] ^ tgt;
      end
   endtask

   task automatic arm_model();
      exp_s_q.delete();
      exp_ram_q.delete();
      r_s   = s_mem;
      r_rom = rom_mem;
      prga_ref(1'b1);
   endtask

   task automatic load_identity();
      for (int x = 0; x < 256; x++) s_mem[x] = 8'(x);
   endtask

   task automatic load_random_perm();
      logic [7:0] t;
      int y;
      load_identity();
      for (int x = 255; x > 0; x--) begin
         y = $urandom_range(0, x);
         t = s_mem[x]; s_mem[x] = s_mem[y]; s_mem[y] = t;
      end
   endtask

   // ---------------- scoreboard / compare process ----------------
   bit         chk_en   = 1'b0;
   bit         lit_case = 1'b0;
   int         s_wr_cnt, ram_wr_cnt;
   bit         seen_j, seen_f;
   logic [7:0] first_j_addr, first_f_addr;

   always @(negedge clk) begin
      if (chk_en) begin
         if (s_wren) begin
            s_wr_cnt++;
            if (exp_s_q.size() == 0) check("s_wr_unexpected", {s_address, s_data}, 32'hFFFF_FFFF);
            else                     check("s_wr", {s_address, s_data}, exp_s_q.pop_front());
         end
         if (ram_wren) begin
            ram_wr_cnt++;
            if (exp_ram_q.size() == 0) check("ram_wr_unexpected", {3'b000, ram_address, ram_data}, 32'hFFFF_FFFF);
            else                       check("ram_wr", {3'b000, ram_address, ram_data}, exp_ram_q.pop_front());
            if (lit_case && ram_address == 5'd1) begin
               check("s2_after_byte1", s_mem[2], 8'h03);
               check("s3_after_byte1", s_mem[3], 8'h02);
            end
         end
         if (state_dbg == ADDR_SJ && !seen_j) begin seen_j = 1'b1; first_j_addr = s_address; end
         if (state_dbg == ADDR_F && !seen_f)  begin seen_f = 1'b1; first_f_addr = s_address; end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic clear_counts();
      s_wr_cnt = 0; ram_wr_cnt = 0; seen_j = 1'b0; seen_f = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_s_address"}, s_address, 8'h00);
      check({tag, "_s_data"}, s_data, 8'h00);
      check({tag, "_s_wren"}, s_wren, 1'b0);
      check({tag, "_rom_address"}, rom_address, 5'd0);
      check({tag, "_ram_address"}, ram_address, 5'd0);
      check({tag, "_ram_data"}, ram_data, 8'h00);
      check({tag, "_ram_wren"}, ram_wren, 1'b0);
      check({tag, "_complete"}, complete, 1'b0);
      check({tag, "_valid"}, valid, 1'b0);
      check({tag, "_state"}, 32'(state_dbg), 32'(IDLE));
   endtask

   // Cycle 0 is the IDLE cycle in which start is high; INC_I is cycle 1.
   task automatic run_case(input string tag, output int cyc);
      bit done;
      clear_counts();
      chk_en = 1'b1;
      @(negedge clk);
      start = 1'b1;
      cyc = 0;
      @(posedge clk);
      #1 start = 1'b0;
      done = 1'b0;
      while (!done && cyc < 2000) begin
         @(negedge clk);
         cyc++;
         if (complete) done = 1'b1;
      end
      check({tag, "_completed"}, done, 1'b1);
      check({tag, "_cycles"}, cyc, 12 * r_bytes + 1);
      check({tag, "_valid"}, valid, r_valid);
      check({tag, "_ram_wr_cnt"}, ram_wr_cnt, r_bytes);
      check({tag, "_s_wr_cnt"}, s_wr_cnt, 2 * r_bytes);
      check({tag, "_s_left"}, exp_s_q.size(), 0);
      check({tag, "_ram_left"}, exp_ram_q.size(), 0);
      check({tag, "_first_j"}, first_j_addr, r_first_j);
      check({tag, "_first_fidx"}, first_f_addr, r_first_fidx);
      chk_en = 1'b0;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int cyc, b1, b2;
      bit v1, v2, hit, done;
      logic [7:0] bad;

      reset_n = 1'b0;
      start   = 1'b0;
      load_identity();
      for (int k = 0; k < N; k++) begin rom_mem[k] = 8'h00; ram_mem[k] = 8'h00; end
      #12;
      check_all_zero("reset");
      @(negedge clk);
      reset_n = 1'b1;

      // Identity S: known keystream, all bytes decrypt to 'a'.
      load_identity();
      prep_rom(-1, 8'h00, 1'b0);
      check("rom0_literal", rom_mem[0], 8'h63);
      check("rom1_literal", rom_mem[1], 8'h64);
      arm_model();
      check("model_ram0", r_out[0], 8'h61);
      check("model_ram1", r_out[1], 8'h61);
      lit_case = 1'b1;
      run_case("clean", cyc);
      lit_case = 1'b0;
      check("clean_cycles_literal", cyc, 385);
      check("clean_valid_literal", valid, 1'b1);
      check("clean_s_writes_literal", s_wr_cnt, 64);
      check("ram0_literal", ram_mem[0], 8'h61);
      check("ram1_literal", ram_mem[1], 8'h61);
      repeat (3) @(negedge clk);
      check("valid_held", valid, 1'b1);
      check("idle_after_done", 32'(state_dbg), 32'(IDLE));

      // Byte 3 decrypts to 8'h7B: abort.
      load_identity();
      prep_rom(3, 8'h7B, 1'b0);
      arm_model();
      check("model_abort_bytes", r_bytes, 4);
      run_case("abort", cyc);
      check("abort_cycles_literal", cyc, 49);
      check("abort_valid_literal", valid, 1'b0);
      check("abort_ram_wr_literal", ram_wr_cnt, 4);

      // j and f-index wrap past 8'hFF.
      load_identity();
      s_mem[0]   = 8'h02;
      s_mem[1]   = 8'hFF;
      s_mem[255] = 8'h02;
      prep_rom(-1, 8'h00, 1'b1);
      arm_model();
      run_case("wrap", cyc);
      check("wrap_j_literal", first_j_addr, 8'hFF);
      check("wrap_fidx_literal", first_f_addr, 8'h01);

      // Random permutations and random text, sometimes with a bad byte.
      for (int r = 0; r < 6; r++) begin
         load_random_perm();
         do bad = 8'($urandom_range(0, 255)); while (is_text(bad));
         prep_rom(($urandom_range(0, 1) == 1) ? $urandom_range(0, N - 1) : -1, bad, 1'b1);
         arm_model();
         run_case("random", cyc);
      end

      // Reset during WR_SJ of byte 10, then a clean run on the partial S.
      load_identity();
      prep_rom(-1, 8'h00, 1'b0);
      arm_model();
      clear_counts();
      chk_en = 1'b1;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      hit = 1'b0;
      for (int c = 0; c < 2000 && !hit; c++) begin
         @(negedge clk);
         if (state_dbg == WR_SJ && rom_address == 5'd10) hit = 1'b1;
      end
      check("midrun_reached", hit, 1'b1);
      reset_n = 1'b0;
      #1;
      chk_en = 1'b0;
      exp_s_q.delete();
      exp_ram_q.delete();
      check_all_zero("midrun_reset");
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check("post_reset_idle", 32'(state_dbg), 32'(IDLE));
         check("post_reset_s_wren", s_wren, 1'b0);
      end
      prep_rom(-1, 8'h00, 1'b0);
      arm_model();
      run_case("after_reset", cyc);
      check("after_reset_valid", valid, 1'b1);

      // start held high: back-to-back runs.
      load_identity();
      prep_rom(-1, 8'h00, 1'b0);
      arm_model();
      b1 = r_bytes; v1 = r_valid;
      prga_ref(1'b1);
      b2 = r_bytes; v2 = r_valid;
      clear_counts();
      chk_en = 1'b1;
      @(negedge clk);
      start = 1'b1;
      cyc = 0;
      done = 1'b0;
      while (!done && cyc < 2000) begin
         @(negedge clk); cyc++;
         if (complete) done = 1'b1;
      end
      check("b2b_first_cycles", cyc, 12 * b1 + 1);
      check("b2b_first_valid", valid, v1);
      @(negedge clk); cyc++;
      check("b2b_gap_idle", 32'(state_dbg), 32'(IDLE));
      check("b2b_gap_complete", complete, 1'b0);
      check("b2b_gap_valid", valid, v1);
      @(negedge clk); cyc++;
      check("b2b_restart", 32'(state_dbg), 32'(INC_I));
      check("b2b_valid_cleared", valid, 1'b0);
      done = 1'b0;
      while (!done && cyc < 4000) begin
         @(negedge clk); cyc++;
         if (complete) done = 1'b1;
      end
      start = 1'b0;
      check("b2b_second_cycles", cyc, 12 * b1 + 2 + 12 * b2 + 1);
      check("b2b_second_valid", valid, v2);
      check("b2b_s_wr_cnt", s_wr_cnt, 2 * (b1 + b2));
      repeat (2) @(negedge clk);
      check("b2b_stays_idle", 32'(state_dbg), 32'(IDLE));
      check("b2b_s_left", exp_s_q.size(), 0);
      check("b2b_ram_left", exp_ram_q.size(), 0);
      chk_en = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
